ddr_init_sequencer: RTL and testbench



---
 rtl/ddr_init_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_ddr_init_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_init_sequencer.sv
// DDR4 power-up sequencer: reset hold, CKE, MR3..MR0 writes, optional ZQCL,
// then the MR0 update path. Optional ZQ calibration: define INIT_ZQCAL_EN.
// Ports: clock_t, reset (sync, active-high), mrs_update_rdy/_cmd (MR0 update
// request), cke, cmd, mr_sel, mr_data, config_done, mr0, update_busy.
module ddr_init_sequencer #(
  parameter int MRS_WIDTH = 14,
  parameter int T_RESET   = 20,
  parameter int T_XPR     = 10,
  parameter int T_MRD     = 8,
  parameter int T_MOD     = 24,
  parameter int T_ZQINIT  = 64,
  parameter logic [MRS_WIDTH-1:0] MR0_INIT = MRS_WIDTH'('h0210),
  parameter logic [MRS_WIDTH-1:0] MR1_INIT = '0,
  parameter logic [MRS_WIDTH-1:0] MR2_INIT = '0,
  parameter logic [MRS_WIDTH-1:0] MR3_INIT = '0,
  parameter logic [MRS_WIDTH-1:0] MR4_INIT = '0,
  parameter logic [MRS_WIDTH-1:0] MR5_INIT = '0,
  parameter logic [MRS_WIDTH-1:0] MR6_INIT = '0
) (
  input  logic                 clock_t,
  input  logic                 reset,
  input  logic                 mrs_update_rdy,
  input  logic [MRS_WIDTH-1:0] mrs_update_cmd,
  output logic                 cke,
  output logic [1:0]           cmd,
  output logic [2:0]           mr_sel,
  output logic [MRS_WIDTH-1:0] mr_data,
  output logic                 config_done,
  output logic [MRS_WIDTH-1:0] mr0,
  output logic                 update_busy
);

  localparam int TA = (T_RESET > T_XPR) ? T_RESET : T_XPR;
  localparam int TB = (TA > T_MRD) ? TA : T_MRD;
  localparam int TC = (TB > T_MOD) ? TB : T_MOD;
  localparam int TM = (TC > T_ZQINIT) ? TC : T_ZQINIT;
  localparam int CW = $clog2(TM + 1);

  // Outputs lag the state by one register stage, so a state occupied
  // for L cycles exits when its counter reads L-1.
  localparam logic [CW-1:0] TC_RST = CW'(T_RESET - 1);
  localparam logic [CW-1:0] TC_XPR = CW'(T_XPR - 1);
  localparam logic [CW-1:0] TC_MRD = CW'(T_MRD - 2);
  localparam logic [CW-1:0] TC_MOD = CW'(T_MOD - 2);
`ifdef INIT_ZQCAL_EN
  localparam logic [CW-1:0] TC_ZQ  = CW'(T_ZQINIT - 2);
  localparam logic [1:0]    CMD_ZQ = 2'b10;
`endif
  localparam logic [1:0] CMD_DES = 2'b00;
  localparam logic [1:0] CMD_MRS = 2'b01;

  typedef enum logic [3:0] {
    RST_HOLD, XPR_WAIT, MRS_ISSUE, MRS_GAP,
`ifdef INIT_ZQCAL_EN
    ZQ_ISSUE, ZQ_WAIT,
`endif
    DONE, UPD_ISSUE, UPD_WAIT
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [MRS_WIDTH-1:0]  upd_q, upd_d;
  logic                  cke_q, cke_d;
  logic [1:0]            cmd_q, cmd_d;
  logic [2:0]            sel_q, sel_d;
  logic [MRS_WIDTH-1:0]  data_q, data_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic [MRS_WIDTH-1:0]  mr0_q, mr0_d;
  logic [2:0]            mr_num;
  logic [MRS_WIDTH-1:0]  mr_val;

  always_ff @(posedge clock_t) begin
    if (reset) begin
      state_q <= RST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      upd_q   <= MR0_INIT;
      cke_q   <= 1'b0;
      cmd_q   <= CMD_DES;
      sel_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      mr0_q   <= MR0_INIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      upd_q   <= upd_d;
      cke_q   <= cke_d;
      cmd_q   <= cmd_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      mr0_q   <= mr0_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    upd_d   = upd_q;
    unique case (state_q)
      RST_HOLD: if (cnt_q == TC_RST) begin
        state_d = XPR_WAIT;
        cnt_d   = '0;
      end
      XPR_WAIT: if (cnt_q == TC_XPR) begin
        state_d = MRS_ISSUE;
        cnt_d   = '0;
      end
      MRS_ISSUE: begin
        state_d = MRS_GAP;
        cnt_d   = '0;
      end
      MRS_GAP: begin
        if (idx_q == 3'd6) begin
          if (cnt_q == TC_MOD) begin
`ifdef INIT_ZQCAL_EN
            state_d = ZQ_ISSUE;
`else
            state_d = DONE;
`endif
            cnt_d = '0;
          end
        end else if (cnt_q == TC_MRD) begin
          state_d = MRS_ISSUE;
          idx_d   = idx_q + 3'd1;
          cnt_d   = '0;
        end
      end
`ifdef INIT_ZQCAL_EN
      ZQ_ISSUE: begin
        state_d = ZQ_WAIT;
        cnt_d   = '0;
      end
      ZQ_WAIT: if (cnt_q == TC_ZQ) begin
        state_d = DONE;
        cnt_d   = '0;
      end
`endif
      DONE: begin
        cnt_d = '0;
        if (mrs_update_rdy) begin
          upd_d   = mrs_update_cmd;
          state_d = UPD_ISSUE;
        end
      end
      UPD_ISSUE: begin
        state_d = UPD_WAIT;
        cnt_d   = '0;
      end
      UPD_WAIT: if (cnt_q == TC_MOD) begin
        state_d = DONE;
        cnt_d   = '0;
      end
      default: state_d = RST_HOLD;
    endcase
  end

  // Walk order MR3, MR6, MR5, MR4, MR2, MR1, MR0.
  always_comb begin
    mr_num = 3'd0;
    unique case (idx_q)
      3'd0:    mr_num = 3'd3;
      3'd1:    mr_num = 3'd6;
      3'd2:    mr_num = 3'd5;
      3'd3:    mr_num = 3'd4;
      3'd4:    mr_num = 3'd2;
      3'd5:    mr_num = 3'd1;
      default: mr_num = 3'd0;
    endcase
    mr_val = mr0_q;
    unique case (mr_num)
      3'd1:    mr_val = MR1_INIT;
      3'd2:    mr_val = MR2_INIT;
      3'd3:    mr_val = MR3_INIT;
      3'd4:    mr_val = MR4_INIT;
      3'd5:    mr_val = MR5_INIT;
      3'd6:    mr_val = MR6_INIT;
      default: mr_val = mr0_q;
    endcase
  end

  always_comb begin
    cke_d  = (state_q != RST_HOLD);
    cmd_d  = CMD_DES;
    sel_d  = '0;
    data_d = '0;
    done_d = (state_q == DONE) || (state_q == UPD_ISSUE) ||
             (state_q == UPD_WAIT);
    busy_d = (state_q == UPD_ISSUE) || (state_q == UPD_WAIT);
    mr0_d  = mr0_q;
    unique case (state_q)
      MRS_ISSUE: begin
        cmd_d  = CMD_MRS;
        sel_d  = mr_num;
        data_d = mr_val;
      end
`ifdef INIT_ZQCAL_EN
      ZQ_ISSUE: cmd_d = CMD_ZQ;
`endif
      UPD_ISSUE: begin
        cmd_d  = CMD_MRS;
        data_d = upd_q;
        mr0_d  = upd_q;
      end
      default: ;
    endcase
  end

  assign cke         = cke_q;
  assign cmd         = cmd_q;
  assign mr_sel      = sel_q;
  assign mr_data     = data_q;
  assign config_done = done_q;
  assign mr0         = mr0_q;
  assign update_busy = busy_q;

endmodule

// File: tb/tb_ddr_init_sequencer.sv
// Self-checking bench for ddr_init_sequencer: init sequence table,
// MR0 update handshake, ignored requests, and resets mid-sequence.
module tb_ddr_init_sequencer;

  localparam int W = 14;
`ifdef INIT_ZQCAL_EN
  localparam bit ZQ = 1'b1;
`else
  localparam bit ZQ = 1'b0;
`endif
  localparam logic [1:0] DES = 2'b00;
  localparam logic [1:0] MRS = 2'b01;
  localparam logic [1:0] ZQC = 2'b10;

  logic         clock_t = 1'b0;
  logic         reset = 1'b1;
  logic         mrs_update_rdy = 1'b0;
  logic [W-1:0] mrs_update_cmd = '0;
  logic         cke;
  logic [1:0]   cmd;
  logic [2:0]   mr_sel;
  logic [W-1:0] mr_data;
  logic         config_done;
  logic [W-1:0] mr0;
  logic         update_busy;

  int errors = 0;
  int checks = 0;
  int cyc;

  ddr_init_sequencer dut (
    .clock_t(clock_t), .reset(reset),
    .mrs_update_rdy(mrs_update_rdy),
    .mrs_update_cmd(mrs_update_cmd),
    .cke(cke), .cmd(cmd), .mr_sel(mr_sel),
    .mr_data(mr_data), .config_done(config_done),
    .mr0(mr0), .update_busy(update_busy)
  );

  always #5 clock_t = ~clock_t;

  typedef struct {
    int         c;
    bit         rdy;
    logic [W-1:0] ucmd;
    bit         cke;
    logic [1:0] cmd;
    logic [2:0] sel;
    logic [W-1:0] data;
    bit         done;
    logic [W-1:0] mr0;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int c, bit r, logic [W-1:0] u,
                              bit k, logic [1:0] cm, logic [2:0] s,
                              logic [W-1:0] d, bit dn,
                              logic [W-1:0] m);
    vec_t v;
    v.c = c; v.rdy = r; v.ucmd = u; v.cke = k; v.cmd = cm;
    v.sel = s; v.data = d; v.done = dn; v.mr0 = m;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_t);
    #1;
    cyc++;
  endtask

  task automatic chk_rst_vals();
    chk("rst_cke", 32'(cke), 0);
    chk("rst_cmd", 32'(cmd), 32'(DES));
    chk("rst_sel", 32'(mr_sel), 0);
    chk("rst_data", 32'(mr_data), 0);
    chk("rst_done", 32'(config_done), 0);
    chk("rst_mr0", 32'(mr0), 32'h0210);
    chk("rst_busy", 32'(update_busy), 0);
  endtask

  int n_mrs, n_zq, n_bad, n_idle_bad, n_busy_lo, n;

  initial begin
    tbl.push_back(mk(0,   0, 0, 0, DES, 0, 0, 0, 'h210));
    tbl.push_back(mk(19,  0, 0, 0, DES, 0, 0, 0, 'h210));
    tbl.push_back(mk(20,  0, 0, 1, DES, 0, 0, 0, 'h210));
    tbl.push_back(mk(29,  0, 0, 1, DES, 0, 0, 0, 'h210));
    tbl.push_back(mk(30,  0, 0, 1, MRS, 3, 0, 0, 'h210));
    tbl.push_back(mk(31,  0, 0, 1, DES, 0, 0, 0, 'h210));
    tbl.push_back(mk(38,  0, 0, 1, MRS, 6, 0, 0, 'h210));
    tbl.push_back(mk(46,  0, 0, 1, MRS, 5, 0, 0, 'h210));
    tbl.push_back(mk(49,  1, 'h3fff, 1, DES, 0, 0, 0, 'h210));
    tbl.push_back(mk(51,  0, 0, 1, DES, 0, 0, 0, 'h210));
    tbl.push_back(mk(54,  0, 0, 1, MRS, 4, 0, 0, 'h210));
    tbl.push_back(mk(62,  0, 0, 1, MRS, 2, 0, 0, 'h210));
    tbl.push_back(mk(70,  0, 0, 1, MRS, 1, 0, 0, 'h210));
    tbl.push_back(mk(78,  0, 0, 1, MRS, 0, 'h210, 0, 'h210));
    tbl.push_back(mk(79,  0, 0, 1, DES, 0, 0, 0, 'h210));
    tbl.push_back(mk(101, 0, 0, 1, DES, 0, 0, 0, 'h210));
    tbl.push_back(mk(102, 0, 0, 1, ZQ ? ZQC : DES, 0, 0, !ZQ, 'h210));
    tbl.push_back(mk(103, 0, 0, 1, DES, 0, 0, !ZQ, 'h210));
    tbl.push_back(mk(165, 0, 0, 1, DES, 0, 0, !ZQ, 'h210));
    tbl.push_back(mk(166, 0, 0, 1, DES, 0, 0, 1, 'h210));

    reset = 1'b1;
    cyc = 0;
    repeat (3) tick();
    chk_rst_vals();
    reset = 1'b0;
    cyc = -1;

    n_mrs = 0; n_zq = 0; n_bad = 0;
    for (int k = 0; k <= 170; k++) begin
      tick();
      mrs_update_rdy = 1'b0;
      if (cmd == MRS) n_mrs++;
      if (cmd == ZQC) n_zq++;
      if (cmd === 2'b11 || $isunknown(cmd)) n_bad++;
      foreach (tbl[i]) begin
        if (tbl[i].c == cyc) begin
          chk($sformatf("cke@%0d", cyc), 32'(cke), 32'(tbl[i].cke));
          chk($sformatf("cmd@%0d", cyc), 32'(cmd), 32'(tbl[i].cmd));
          if (tbl[i].cmd == MRS)
            chk($sformatf("sel@%0d", cyc), 32'(mr_sel), 32'(tbl[i].sel));
          chk($sformatf("data@%0d", cyc), 32'(mr_data), 32'(tbl[i].data));
          chk($sformatf("done@%0d", cyc), 32'(config_done),
              32'(tbl[i].done));
          chk($sformatf("mr0@%0d", cyc), 32'(mr0), 32'(tbl[i].mr0));
          chk($sformatf("busy@%0d", cyc), 32'(update_busy), 0);
          if (tbl[i].rdy) begin
            mrs_update_rdy = 1'b1;
            mrs_update_cmd = tbl[i].ucmd;
          end
        end
      end
    end
    chk("init_mrs_count", 32'(n_mrs), 7);
    chk("init_zq_count", 32'(n_zq), 32'(ZQ));
    chk("init_bad_cmd", 32'(n_bad), 0);

    // MR0 update: request sampled at edge n
    n = cyc + 1;
    mrs_update_rdy = 1'b1;
    mrs_update_cmd = 'h0212;
    tick();
    mrs_update_rdy = 1'b0;
    chk("upd_busy_n", 32'(update_busy), 0);
    chk("upd_cmd_n", 32'(cmd), 32'(DES));
    tick();
    chk("upd_cmd", 32'(cmd), 32'(MRS));
    chk("upd_sel", 32'(mr_sel), 0);
    chk("upd_data", 32'(mr_data), 32'h0212);
    chk("upd_mr0", 32'(mr0), 32'h0212);
    chk("upd_busy", 32'(update_busy), 1);
    chk("upd_done", 32'(config_done), 1);

    n_idle_bad = 0; n_busy_lo = 0;
    for (int k = 2; k <= 24; k++) begin
      tick();
      mrs_update_rdy = 1'b0;
      if (cmd != DES) n_idle_bad++;
      if (update_busy !== 1'b1 || config_done !== 1'b1) n_busy_lo++;
      if (cyc == n + 4) begin
        mrs_update_rdy = 1'b1;
        mrs_update_cmd = 'h1111;
      end
      if (cyc == n + 24) begin
        mrs_update_rdy = 1'b1;
        mrs_update_cmd = 'h0213;
      end
    end
    chk("upd_wait_cmds", 32'(n_idle_bad), 0);
    chk("upd_wait_busy", 32'(n_busy_lo), 0);
    chk("upd_ignored_mr0", 32'(mr0), 32'h0212);
    tick();
    mrs_update_rdy = 1'b0;
    chk("upd_busy_end", 32'(update_busy), 0);
    chk("upd_cmd_end", 32'(cmd), 32'(DES));
    chk("upd_done_end", 32'(config_done), 1);
    tick();
    chk("upd2_cmd", 32'(cmd), 32'(MRS));
    chk("upd2_data", 32'(mr_data), 32'h0213);
    chk("upd2_mr0", 32'(mr0), 32'h0213);
    chk("upd2_busy", 32'(update_busy), 1);

    // reset during UPD_WAIT
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk_rst_vals();

    // reset between MRS commands at cycle 40
    tick();
    reset = 1'b0;
    cyc = -1;
    while (cyc < 39) tick();
    chk("pre40_cke", 32'(cke), 1);
    reset = 1'b1;
    tick();
    chk_rst_vals();
    reset = 1'b0;
    cyc = -1;
    n_mrs = 0;
    while (cyc < 38) begin
      tick();
      if (cmd == MRS) n_mrs++;
      if (cyc == 19) chk("re_cke19", 32'(cke), 0);
      if (cyc == 20) chk("re_cke20", 32'(cke), 1);
      if (cyc == 29) chk("re_cmd29", 32'(cmd), 32'(DES));
      if (cyc == 30) begin
        chk("re_cmd30", 32'(cmd), 32'(MRS));
        chk("re_sel30", 32'(mr_sel), 3);
      end
      if (cyc == 38) chk("re_sel38", 32'(mr_sel), 6);
    end
    chk("re_mrs_count", 32'(n_mrs), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
